accel_mag_sq: RTL and testbench

ACCEL_MAG_SQ -- requirements
Module: accel_mag_sq

---
 rtl/accel_mag_sq.sv | 147 ++++++++++++++
 tb/tb_accel_mag_sq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/accel_mag_sq.sv
// Accelerometer magnitude-squared front end: offset-corrects one 3-axis Q8.8 sample,
// sums the squares through one shared multiplier and hands the Q16.16 result to the sqrt stage.
`timescale 1ns/1ps
module accel_mag_sq #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic [15:0] off_x,
    input  logic [15:0] off_y,
    input  logic [15:0] off_z,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_value,
    output logic        m_start,
    input  logic        m_done,
    output logic        sat,
    output logic        timeout_err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SQX,
        SQY,
        SQZ,
        ISSUE,
        WAIT
    } state_t;

    state_t             state;
    logic [DW-1:0]      dx;
    logic [DW-1:0]      dy;
    logic [DW-1:0]      dz;
    logic [AW-1:0]      acc;
    logic [CNT_W-1:0]   wait_cnt;

    logic [DW:0]        sub_x_c;
    logic [DW:0]        sub_y_c;
    logic [DW:0]        sub_z_c;
    logic [DW-1:0]      mul_op_c;
    logic signed [AW-1:0] prod_c;
    logic [AW-1:0]      acc_sum_c;

    // Returns {saturated, value}: 17-bit difference clamped to the signed 16-bit range.
    function automatic logic [DW:0] sub_sat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] d;
        d = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
        if (d[DW] != d[DW-1]) begin
            sub_sat = {1'b1, d[DW] ? 16'h8000 : 16'h7FFF};
        end else begin
            sub_sat = {1'b0, d[DW-1:0]};
        end
    endfunction

    assign sub_x_c = sub_sat(x_in, off_x);
    assign sub_y_c = sub_sat(y_in, off_y);
    assign sub_z_c = sub_sat(z_in, off_z);

    // Single shared multiplier; the operand follows the squaring state.
    always_comb begin
        mul_op_c = dx;
        case (state)
            SQY:     mul_op_c = dy;
            SQZ:     mul_op_c = dz;
            default: mul_op_c = dx;
        endcase
    end

    assign prod_c    = $signed(mul_op_c) * $signed(mul_op_c);
    assign acc_sum_c = acc + AW'(prod_c);

    // m_value is loaded on the edge into ISSUE so it is already valid while m_start is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            m_start     <= 1'b0;
            m_value     <= '0;
            sat         <= 1'b0;
            timeout_err <= 1'b0;
            acc         <= '0;
            wait_cnt    <= '0;
            dx          <= '0;
            dy          <= '0;
            dz          <= '0;
        end else begin
            m_start     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        dx      <= sub_x_c[DW-1:0];
                        dy      <= sub_y_c[DW-1:0];
                        dz      <= sub_z_c[DW-1:0];
                        sat     <= sub_x_c[DW] | sub_y_c[DW] | sub_z_c[DW];
                        s_ready <= 1'b0;
                        state   <= SQX;
                    end
                end
                SQX: begin
                    acc   <= AW'(prod_c);
                    state <= SQY;
                end
                SQY: begin
                    acc   <= acc_sum_c;
                    state <= SQZ;
                end
                SQZ: begin
                    acc      <= acc_sum_c;
                    m_value  <= acc_sum_c;
                    m_start  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(1);
                    state    <= WAIT;
                end
                WAIT: begin
                    // The ISSUE cycle counts toward the budget; m_done beats expiry.
                    if (m_done) begin
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        s_ready     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    s_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_mag_sq.sv
// Directed + randomized bench for accel_mag_sq against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_accel_mag_sq;

    logic        clk;
    logic        rst;
    logic [15:0] x_in, y_in, z_in;
    logic [15:0] off_x, off_y, off_z;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_value;
    logic        m_start;
    logic        m_done;
    logic        sat;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    accel_mag_sq #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .x_in        (x_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .off_x       (off_x),
        .off_y       (off_y),
        .off_z       (off_z),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_value     (m_value),
        .m_start     (m_start),
        .m_done      (m_done),
        .sat         (sat),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtract, clamp, square and sum.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                  input logic [15:0] ox, input logic [15:0] oy, input logic [15:0] oz,
                                  output logic [31:0] mag, output logic s);
        int     d[3];
        longint sum;
        d[0] = int'($signed(x)) - int'($signed(ox));
        d[1] = int'($signed(y)) - int'($signed(oy));
        d[2] = int'($signed(z)) - int'($signed(oz));
        s   = 1'b0;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            if (d[i] > 32767) begin
                d[i] = 32767;
                s    = 1'b1;
            end else if (d[i] < -32768) begin
                d[i] = -32768;
                s    = 1'b1;
            end
            sum += longint'(d[i]) * longint'(d[i]);
        end
        mag = 32'(sum);
    endfunction

    // One sample through the pipe; m_done returned dly cycles after m_start.
    task automatic run_txn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input int dly, input bit keep_valid, input bit stray);
        logic [31:0] em;
        logic        es;
        model(x, y, z, off_x, off_y, off_z, em, es);
        chk("idle_ready", 32'(s_ready), 32'd1);
        x_in    = x;
        y_in    = y;
        z_in    = z;
        s_valid = 1'b1;
        tick();
        for (int c = 1; c <= 4 + dly; c++) begin
            if (keep_valid) begin
                x_in = 16'($urandom);
                y_in = 16'($urandom);
                z_in = 16'($urandom);
            end else begin
                s_valid = 1'b0;
            end
            chk("busy_ready", 32'(s_ready), 32'd0);
            chk("m_start", 32'(m_start), 32'(c == 4));
            chk("timeout_quiet", 32'(timeout_err), 32'd0);
            if (c >= 4) begin
                chk("m_value", m_value, em);
                chk("sat", 32'(sat), 32'(es));
            end
            m_done = (c == 4 + dly) || (stray && (c == 2 || c == 4));
            tick();
        end
        m_done = 1'b0;
        chk("done_ready", 32'(s_ready), 32'd1);
        chk("done_no_err", 32'(timeout_err), 32'd0);
        chk("done_start_low", 32'(m_start), 32'd0);
    endtask

    task automatic run_timeout(input logic [15:0] x);
        logic [31:0] em;
        logic        es;
        model(x, 16'h0, 16'h0, off_x, off_y, off_z, em, es);
        x_in    = x;
        y_in    = 16'h0;
        z_in    = 16'h0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            chk("to_m_start", 32'(m_start), 32'(c == 4));
            chk("to_err", 32'(timeout_err), 32'(c == 68));
            chk("to_ready", 32'(s_ready), 32'(c == 68));
            if (c == 4) chk("to_m_value", m_value, em);
            tick();
        end
        chk("to_err_one_cycle", 32'(timeout_err), 32'd0);
        chk("to_ready_after", 32'(s_ready), 32'd1);
    endtask

    task automatic run_reset_at(input int at_c);
        x_in    = 16'h0300;
        y_in    = 16'h0200;
        z_in    = 16'h0100;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int c = 1; c < at_c; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_m_value", m_value, 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        for (int c = 0; c < 70; c++) begin
            m_done = (c == 2);
            chk("rst_no_start", 32'(m_start), 32'd0);
            chk("rst_no_err", 32'(timeout_err), 32'd0);
            chk("rst_idle", 32'(s_ready), 32'd1);
            tick();
        end
        m_done = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        m_done  = 1'b0;
        x_in    = '0;
        y_in    = '0;
        z_in    = '0;
        off_x   = '0;
        off_y   = '0;
        off_z   = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        chk("reset_m_start", 32'(m_start), 32'd0);
        chk("reset_m_value", m_value, 32'd0);
        chk("reset_sat", 32'(sat), 32'd0);
        chk("reset_timeout", 32'(timeout_err), 32'd0);

        run_txn(16'h0100, 16'h0000, 16'h0000, 2, 1'b0, 1'b0);
        chk("unit_x_value", m_value, 32'h0001_0000);
        chk("unit_x_sat", 32'(sat), 32'd0);

        run_txn(16'h8000, 16'h8000, 16'h8000, 1, 1'b0, 1'b0);
        chk("max_neg_value", m_value, 32'hC000_0000);
        chk("max_neg_sat", 32'(sat), 32'd0);

        off_x = 16'h8000;
        run_txn(16'h7FFF, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
        chk("pos_sat_value", m_value, 32'h3FFF_0001);
        chk("pos_sat_flag", 32'(sat), 32'd1);
        off_x = 16'h7FFF;
        run_txn(16'h8000, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
        chk("neg_sat_value", m_value, 32'h4000_0000);
        chk("neg_sat_flag", 32'(sat), 32'd1);
        off_x = 16'h0000;

        run_timeout(16'h0080);
        run_txn(16'h0123, 16'hFF00, 16'h0040, 63, 1'b0, 1'b0);
        run_txn(16'h0200, 16'h0100, 16'hFE00, 5, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_txn(16'($urandom), 16'($urandom), 16'($urandom), 3, 1'b1, 1'b0);
        end
        s_valid = 1'b0;
        tick();

        run_reset_at(2);
        run_reset_at(10);
        run_txn(16'h0100, 16'h0100, 16'h0100, 2, 1'b0, 1'b0);
        chk("post_reset_value", m_value, 32'h0003_0000);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                off_x = 16'($urandom);
                off_y = 16'($urandom);
                off_z = 16'($urandom);
            end else begin
                off_x = 16'($urandom_range(0, 511)) - 16'd256;
                off_y = 16'($urandom_range(0, 511)) - 16'd256;
                off_z = 16'($urandom_range(0, 511)) - 16'd256;
            end
            run_txn(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(1, 6)),
                    1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
